// File: rtl/wave_capture_pingpong_pkg.sv
// Shared types and constants for the wave-capture ping-pong writer.
package wave_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_t;

  localparam int         SAMPLES_PER_HALF = 256;
  localparam logic [7:0] OUT_OFFSET       = 8'd128;

endpackage

// File: rtl/zero_cross_detect.sv
// Remembers the previous sample and flags a negative -> non-negative crossing.
module zero_cross_detect #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  output logic                crossing_o
);

  logic [SAMPLE_W-1:0] prev_sample_q;

  // Track the last sample on every strobe, regardless of capture state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              prev_sample_q <= '0;
    else if (new_sample_ready) prev_sample_q <= new_sample_in;
  end

  // Zero counts as non-negative, so only the sign bits matter.
  always_comb begin
    crossing_o = new_sample_ready & prev_sample_q[SAMPLE_W-1] & ~new_sample_in[SAMPLE_W-1];
  end

endmodule

// File: rtl/wave_capture_pingpong.sv
// Captures 256 samples after a rising zero crossing into the idle half of a
// ping-pong RAM, then flips the display's read half at end of frame.
module wave_capture_pingpong
  import wave_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = $bits(OUT_OFFSET),
  parameter int DEPTH_LOG2 = $clog2(SAMPLES_PER_HALF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  new_sample_ready,
  input  logic [SAMPLE_W-1:0]   new_sample_in,
  input  logic                  wave_display_idle,
  output logic [DEPTH_LOG2:0]   write_address,
  output logic                  write_enable,
  output logic [OUT_W-1:0]      write_sample,
  output logic                  read_index
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};

  cap_state_t            state_q;
  logic [DEPTH_LOG2-1:0] count_q;
  logic                  read_index_q;
  logic                  we_q;
  logic [DEPTH_LOG2:0]   waddr_q;
  logic [OUT_W-1:0]      wsample_q;
  logic                  crossing;
  logic [OUT_W-1:0]      sample_ob;

  zero_cross_detect #(.SAMPLE_W(SAMPLE_W)) u_zcd (
    .clk              (clk),
    .reset_n          (reset_n),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .crossing_o       (crossing)
  );

  // Offset-binary: keep the top bits and invert the sign (same as +half-scale).
  always_comb begin
    sample_ob = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: OUT_W-1]};
  end

  // Capture FSM with registered write port; writes target ~read_index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARMED;
      count_q      <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wsample_q    <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ARMED: begin
          if (crossing) begin
            we_q      <= 1'b1;
            waddr_q   <= {~read_index_q, {DEPTH_LOG2{1'b0}}};
            wsample_q <= sample_ob;
            count_q   <= DEPTH_LOG2'(1);
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            we_q      <= 1'b1;
            waddr_q   <= {~read_index_q, count_q};
            wsample_q <= sample_ob;
            count_q   <= count_q + 1'b1;  // wraps to 0 after the last slot
            if (count_q == LAST_IDX) state_q <= WAIT;
          end
        end
        WAIT: begin
          // No write can be pending here: the last write left on entry.
          if (wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state_q      <= ARMED;
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_sample  = wsample_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture_pingpong.sv
// Bench for wave_capture_pingpong: constant vector table, directed capture
// sequences and a randomized run against a transaction-level model.
module tb_wave_capture_pingpong;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture_pingpong dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "samples still to store" plus a pending-flip flag.
  logic [15:0] m_prev;
  int          m_left;
  bit          m_wait;
  bit          m_half;
  bit          m_we;
  int          m_addr;
  int          m_data;

  function automatic int ob(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    v = v >>> 8;                 // floor(s / 256)
    return (v + 128) & 255;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_left = 0; m_wait = 0; m_half = 0;
    m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step(input logic rdy, input logic [15:0] s, input logic idle);
    int idx;
    bit wr;
    wr = 0; idx = 0;
    m_we = 0;
    if (m_wait) begin
      if (idle) begin m_half = !m_half; m_wait = 0; end
    end else if (m_left > 0) begin
      if (rdy) begin
        idx = 256 - m_left; wr = 1; m_left--;
        if (m_left == 0) m_wait = 1;
      end
    end else if (rdy && $signed(m_prev) < 0 && $signed(s) >= 0) begin
      idx = 0; wr = 1; m_left = 255;
    end
    if (wr) begin
      m_we = 1;
      m_addr = (m_half ? 0 : 256) + idx;
      m_data = ob(s);
    end
    if (rdy) m_prev = s;
  endtask

  // One clock: drive on negedge, model the edge, check 1 ns after it.
  task automatic step(input logic rdy, input logic [15:0] s, input logic idle);
    @(negedge clk);
    new_sample_ready = rdy; new_sample_in = s; wave_display_idle = idle;
    @(posedge clk);
    model_step(rdy, s, idle);
    #1;
    chk("mdl_we",   32'(write_enable),  32'(m_we));
    chk("mdl_addr", 32'(write_address), 32'(m_addr));
    chk("mdl_data", 32'(write_sample),  32'(m_data));
    chk("mdl_ridx", 32'(read_index),    32'(m_half));
  endtask

  // Continue a capture: n writes expected at base+first.. with given idle level.
  task automatic feed(input int n, input int base, input int first, input bit rnd,
                      input logic [15:0] s, input logic idle, input logic exp_ri);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 16'($urandom) : s;
      step(1'b1, v, idle);
      chk("cap_we",   32'(write_enable),  32'd1);
      chk("cap_addr", 32'(write_address), 32'(base + first + i));
      chk("cap_ridx", 32'(read_index),    32'(exp_ri));
    end
  endtask

  typedef struct {
    logic        rdy;
    logic [15:0] s;
    logic        idle;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic        ri;
  } vec_t;

  vec_t vt[6];
  int   wr_cnt;

  initial begin
    vt[0] = '{1'b1, 16'h0100, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vt[1] = '{1'b1, 16'h8000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vt[2] = '{1'b1, 16'h0200, 1'b0, 1'b1, 9'h100, 8'h82, 1'b0};
    vt[3] = '{1'b0, 16'h1234, 1'b0, 1'b0, 9'h100, 8'h82, 1'b0};
    vt[4] = '{1'b1, 16'h7F00, 1'b0, 1'b1, 9'h101, 8'hFF, 1'b0};
    vt[5] = '{1'b0, 16'h7F00, 1'b1, 1'b0, 9'h101, 8'hFF, 1'b0};

    reset_n = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   32'(write_enable),  32'd0);
    chk("rst_addr", 32'(write_address), 32'd0);
    chk("rst_data", 32'(write_sample),  32'd0);
    chk("rst_ridx", 32'(read_index),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First capture: table vectors, then the remaining slots back to back.
    for (int i = 0; i < 6; i++) begin
      step(vt[i].rdy, vt[i].s, vt[i].idle);
      chk($sformatf("vec%0d_we", i),   32'(write_enable),  32'(vt[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(write_address), 32'(vt[i].addr));
      chk($sformatf("vec%0d_data", i), 32'(write_sample),  32'(vt[i].data));
      chk($sformatf("vec%0d_ridx", i), 32'(read_index),    32'(vt[i].ri));
    end
    feed(254, 9'h100, 2, 1'b0, 16'h7F00, 1'b0, 1'b0);
    chk("cap1_last_data", 32'(write_sample), 32'hFF);

    // Waiting for the display: samples (including a crossing) are ignored.
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 7) ? 16'h8000 : 16'h0100 + 16'(i), 1'b0);
      if (write_enable) wr_cnt++;
      chk("wait_ridx", 32'(read_index), 32'd0);
    end
    chk("wait_writes", 32'(wr_cnt), 32'd0);
    step(1'b0, 16'h0000, 1'b1);
    chk("flip1_ridx", 32'(read_index),   32'd1);
    chk("flip1_we",   32'(write_enable), 32'd0);

    // Second capture armed by -1 then 0, lands in half 0.
    step(1'b1, 16'hFFFF, 1'b0);
    chk("neg1_we", 32'(write_enable), 32'd0);
    step(1'b1, 16'h0000, 1'b0);
    chk("zero_we",   32'(write_enable),  32'd1);
    chk("zero_addr", 32'(write_address), 32'h000);
    chk("zero_data", 32'(write_sample),  32'h80);
    feed(255, 0, 1, 1'b1, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("flip2_ridx", 32'(read_index), 32'd0);

    // Third capture to half 1, then flip back to read half 1.
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    chk("cap3_addr", 32'(write_address), 32'h100);
    chk("cap3_data", 32'(write_sample),  32'h92);
    feed(255, 9'h100, 1, 1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("flip3_ridx", 32'(read_index), 32'd1);

    // Fourth capture interrupted by an asynchronous reset at count 100.
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    feed(99, 0, 1, 1'b1, 16'h0, 1'b0, 1'b1);
    @(posedge clk);
    model_step(new_sample_ready, new_sample_in, wave_display_idle);
    #3;
    new_sample_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_we",   32'(write_enable),  32'd0);
    chk("arst_addr", 32'(write_address), 32'd0);
    chk("arst_data", 32'(write_sample),  32'd0);
    chk("arst_ridx", 32'(read_index),    32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // After reset, idle held high through ARMED and ACTIVE: no early flip.
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(i * 16'h0300), 1'b1);
      if (write_enable) wr_cnt++;
      chk("post_rst_ridx", 32'(read_index), 32'd0);
    end
    chk("post_rst_writes", 32'(wr_cnt), 32'd0);
    step(1'b1, 16'h8000, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    chk("idle_cap_addr", 32'(write_address), 32'h100);
    chk("idle_cap_data", 32'(write_sample),  32'h80);
    feed(255, 9'h100, 1, 1'b0, 16'h7F00, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("idle_flip_ridx", 32'(read_index),   32'd1);
    chk("idle_flip_we",   32'(write_enable), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      logic        r;
      logic        id;
      logic [15:0] s;
      r  = ($urandom_range(0, 3) != 0);
      id = ($urandom_range(0, 5) == 0);
      s  = 16'($urandom);
      step(r, s, id);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
